// File: rtl/cdb_arbiter.sv
// Round-robin arbiter granting up to CDB_WIDTH writeback requesters per cycle onto registered CDB slots.
// Optional macro CDB_ARB_STATS_EN adds saturating per-requester stall_cnt/grant_cnt outputs.
module cdb_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int CDB_WIDTH = 2,
    parameter int ROB_IDX   = 5,
    parameter int PRF_IDX   = 6,
    parameter int DATA_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ROB_IDX-1:0]    req_rob_id,
    input  logic [NUM_REQ*PRF_IDX-1:0]    req_rd_phy,
    input  logic [NUM_REQ*DATA_W-1:0]     req_rd_value,
    output logic [CDB_WIDTH-1:0]          cdb_valid,
    output logic [CDB_WIDTH*ROB_IDX-1:0]  cdb_rob_id,
    output logic [CDB_WIDTH*PRF_IDX-1:0]  cdb_rd_phy,
    output logic [CDB_WIDTH*DATA_W-1:0]   cdb_rd_value
`ifdef CDB_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]         stall_cnt,
    output logic [NUM_REQ*32-1:0]         grant_cnt
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (CDB_WIDTH > NUM_REQ) begin : g_bad_cfg
        $error("cdb_arbiter: CDB_WIDTH must not exceed NUM_REQ");
    end

    logic [PTR_W-1:0]             rr_ptr_r;
    logic [PTR_W-1:0]             next_ptr_s;
    logic [NUM_REQ-1:0]           grant_s;
    logic [CDB_WIDTH-1:0]         slot_valid_s;
    logic [CDB_WIDTH*ROB_IDX-1:0] slot_rob_s;
    logic [CDB_WIDTH*PRF_IDX-1:0] slot_phy_s;
    logic [CDB_WIDTH*DATA_W-1:0]  slot_val_s;
    int                           off_s  [NUM_REQ];
    int                           rank_s [NUM_REQ];
    int                           best_off_s;
    logic                         hit_s;

    // Rank each valid requester by its scan distance from rr_ptr; the first CDB_WIDTH win, rank = slot.
    always_comb begin
        grant_s      = '0;
        slot_valid_s = '0;
        slot_rob_s   = '0;
        slot_phy_s   = '0;
        slot_val_s   = '0;
        next_ptr_s   = rr_ptr_r;
        best_off_s   = -1;
        hit_s        = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            off_s[i] = (i + NUM_REQ - int'(rr_ptr_r)) % NUM_REQ;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            rank_s[i] = 0;
            for (int j = 0; j < NUM_REQ; j++) begin
                rank_s[i] = rank_s[i] + int'(req_valid[j] && (off_s[j] < off_s[i]));
            end
            grant_s[i] = req_valid[i] && (rank_s[i] < CDB_WIDTH);
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            hit_s      = grant_s[i] && (off_s[i] > best_off_s);
            next_ptr_s = hit_s ? PTR_W'((i + 1) % NUM_REQ) : next_ptr_s;
            best_off_s = hit_s ? off_s[i] : best_off_s;
        end
        for (int k = 0; k < CDB_WIDTH; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                hit_s = grant_s[i] && (rank_s[i] == k);
                slot_valid_s[k] = slot_valid_s[k] | hit_s;
                slot_rob_s[k*ROB_IDX +: ROB_IDX] = hit_s ? req_rob_id[i*ROB_IDX +: ROB_IDX]
                                                         : slot_rob_s[k*ROB_IDX +: ROB_IDX];
                slot_phy_s[k*PRF_IDX +: PRF_IDX] = hit_s ? req_rd_phy[i*PRF_IDX +: PRF_IDX]
                                                         : slot_phy_s[k*PRF_IDX +: PRF_IDX];
                slot_val_s[k*DATA_W +: DATA_W]   = hit_s ? req_rd_value[i*DATA_W +: DATA_W]
                                                         : slot_val_s[k*DATA_W +: DATA_W];
            end
        end
    end

    // Flush and reset both suppress every grant in the current cycle.
    assign req_ready = grant_s & {NUM_REQ{~flush & ~rst}};

    // Register winners onto the CDB for one cycle and advance the round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r     <= '0;
            cdb_valid    <= '0;
            cdb_rob_id   <= '0;
            cdb_rd_phy   <= '0;
            cdb_rd_value <= '0;
        end else if (flush) begin
            rr_ptr_r  <= rr_ptr_r;
            cdb_valid <= '0;
        end else begin
            rr_ptr_r  <= next_ptr_s;
            cdb_valid <= slot_valid_s;
            for (int k = 0; k < CDB_WIDTH; k++) begin
                if (slot_valid_s[k]) begin
                    cdb_rob_id[k*ROB_IDX +: ROB_IDX] <= slot_rob_s[k*ROB_IDX +: ROB_IDX];
                    cdb_rd_phy[k*PRF_IDX +: PRF_IDX] <= slot_phy_s[k*PRF_IDX +: PRF_IDX];
                    cdb_rd_value[k*DATA_W +: DATA_W] <= slot_val_s[k*DATA_W +: DATA_W];
                end else begin
                    cdb_rob_id[k*ROB_IDX +: ROB_IDX] <= cdb_rob_id[k*ROB_IDX +: ROB_IDX];
                    cdb_rd_phy[k*PRF_IDX +: PRF_IDX] <= cdb_rd_phy[k*PRF_IDX +: PRF_IDX];
                    cdb_rd_value[k*DATA_W +: DATA_W] <= cdb_rd_value[k*DATA_W +: DATA_W];
                end
            end
        end
    end

`ifdef CDB_ARB_STATS_EN
    // Saturating per-requester stall/grant counters; flush does not clear them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            grant_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && !req_ready[i] && (stall_cnt[i*32 +: 32] != {32{1'b1}})) begin
                    stall_cnt[i*32 +: 32] <= stall_cnt[i*32 +: 32] + 32'd1;
                end else begin
                    stall_cnt[i*32 +: 32] <= stall_cnt[i*32 +: 32];
                end
                if (req_ready[i] && (grant_cnt[i*32 +: 32] != {32{1'b1}})) begin
                    grant_cnt[i*32 +: 32] <= grant_cnt[i*32 +: 32] + 32'd1;
                end else begin
                    grant_cnt[i*32 +: 32] <= grant_cnt[i*32 +: 32];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_cdb_arbiter;
    localparam int NR = 4;
    localparam int CW = 2;
    localparam int RI = 5;
    localparam int PI = 6;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst = 1'b1;
    logic           flush = 1'b0;
    logic [NR-1:0]  req_valid = '0;
    logic [NR-1:0]  req_ready;
    logic [NR*RI-1:0] req_rob_id = '0;
    logic [NR*PI-1:0] req_rd_phy = '0;
    logic [NR*DW-1:0] req_rd_value = '0;
    logic [CW-1:0]  cdb_valid;
    logic [CW*RI-1:0] cdb_rob_id;
    logic [CW*PI-1:0] cdb_rd_phy;
    logic [CW*DW-1:0] cdb_rd_value;
`ifdef CDB_ARB_STATS_EN
    logic [NR*32-1:0] stall_cnt;
    logic [NR*32-1:0] grant_cnt;
`endif

    cdb_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rob_id(req_rob_id), .req_rd_phy(req_rd_phy), .req_rd_value(req_rd_value),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
        .cdb_rd_phy(cdb_rd_phy), .cdb_rd_value(cdb_rd_value)
`ifdef CDB_ARB_STATS_EN
        , .stall_cnt(stall_cnt), .grant_cnt(grant_cnt)
`endif
    );

    int checks = 0;
    int failures = 0;

    function automatic logic [RI-1:0] rob_of(input int i);
        return RI'(req_rob_id >> (i * RI));
    endfunction
    function automatic logic [PI-1:0] phy_of(input int i);
        return PI'(req_rd_phy >> (i * PI));
    endfunction
    function automatic logic [DW-1:0] val_of(input int i);
        return DW'(req_rd_value >> (i * DW));
    endfunction

    task automatic set_payload(input int i, input logic [RI-1:0] r, input logic [PI-1:0] p, input logic [DW-1:0] d);
        req_rob_id[i*RI +: RI]   = r;
        req_rd_phy[i*PI +: PI]   = p;
        req_rd_value[i*DW +: DW] = d;
    endtask

    // Reference: list valid requesters in round-robin scan order, take the first CW.
    function automatic void arb_model(input logic [NR-1:0] v, input logic fl, input int ptr,
                                      output logic [NR-1:0] rdy, output int w0, output int w1,
                                      output int nw, output int nptr);
        int order[$];
        for (int j = 0; j < NR; j++) begin
            int idx = (ptr + j) % NR;
            if (((v >> idx) & 4'b0001) != 4'b0000) order.push_back(idx);
        end
        nw = fl ? 0 : ((order.size() > CW) ? CW : order.size());
        rdy = '0;
        for (int k = 0; k < nw; k++) rdy = rdy | (4'b0001 << order[k]);
        w0 = (nw > 0) ? order[0] : 0;
        w1 = (nw > 1) ? order[1] : 0;
        nptr = (nw > 0) ? (order[nw-1] + 1) % NR : ptr;
    endfunction

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1; flush = 1'b0; req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            checks++;
            if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready cyc=%0d got=%b exp=0000", c, req_ready); end
            checks++;
            if (cdb_valid !== 2'b00) begin failures++; $display("FAIL reset_cdb_valid cyc=%0d got=%b exp=00", c, cdb_valid); end
        end
        checks++;
        if (cdb_rob_id !== '0 || cdb_rd_phy !== '0 || cdb_rd_value !== '0) begin
            failures++; $display("FAIL reset_payload got=%h/%h/%h exp=0", cdb_rob_id, cdb_rd_phy, cdb_rd_value);
        end
        @(negedge clk);
        rst = 1'b0; req_valid = '0;
    endtask

    task automatic test_basic();
        @(negedge clk);
        set_payload(2, 5'd5, 6'd17, 32'hDEADBEEF);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin failures++; $display("FAIL basic_ready got=%b exp=0100", req_ready); end
        @(posedge clk); #1;
        checks++;
        if (cdb_valid !== 2'b01) begin failures++; $display("FAIL basic_cdb_valid got=%b exp=01", cdb_valid); end
        checks++;
        if (cdb_rob_id[4:0] !== 5'd5 || cdb_rd_phy[5:0] !== 6'd17 || cdb_rd_value[31:0] !== 32'hDEADBEEF) begin
            failures++; $display("FAIL basic_slot0 got=%0d/%0d/%h exp=5/17/deadbeef", cdb_rob_id[4:0], cdb_rd_phy[5:0], cdb_rd_value[31:0]);
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_contention();
        reset_pulse();
        for (int i = 0; i < NR; i++) set_payload(i, RI'(10 + i), PI'(20 + i), 32'hA000_0000 + 32'(i));
        for (int c = 0; c < 4; c++) begin
            int first = (c % 2) * 2;
            @(negedge clk);
            req_valid = 4'b1111;
            #1;
            checks++;
            if (req_ready !== ((c % 2 == 0) ? 4'b0011 : 4'b1100)) begin
                failures++; $display("FAIL contention_ready cyc=%0d got=%b", c, req_ready);
            end
            @(posedge clk); #1;
            checks++;
            if (cdb_valid !== 2'b11) begin failures++; $display("FAIL contention_cdb_valid cyc=%0d got=%b exp=11", c, cdb_valid); end
            checks++;
            if (cdb_rob_id[4:0] !== RI'(10 + first) || cdb_rob_id[9:5] !== RI'(11 + first)) begin
                failures++; $display("FAIL contention_slots cyc=%0d got=%0d,%0d exp=%0d,%0d", c, cdb_rob_id[4:0], cdb_rob_id[9:5], 10 + first, 11 + first);
            end
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_wrap();
        @(negedge clk);
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = 4'b1001;
        #1;
        checks++;
        if (req_ready !== 4'b1001) begin failures++; $display("FAIL wrap_ready got=%b exp=1001", req_ready); end
        @(posedge clk); #1;
        checks++;
        if (cdb_valid !== 2'b11 || cdb_rob_id[4:0] !== rob_of(3) || cdb_rob_id[9:5] !== rob_of(0)) begin
            failures++; $display("FAIL wrap_slots got=%b %0d,%0d exp=11 %0d,%0d", cdb_valid, cdb_rob_id[4:0], cdb_rob_id[9:5], rob_of(3), rob_of(0));
        end
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0110) begin failures++; $display("FAIL wrap_ptr_next got=%b exp=0110", req_ready); end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_flush();
        @(negedge clk);
        req_valid = 4'b1111; flush = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin failures++; $display("FAIL flush_ready got=%b exp=0000", req_ready); end
        @(posedge clk); #1;
        checks++;
        if (cdb_valid !== 2'b00) begin failures++; $display("FAIL flush_cdb_valid got=%b exp=00", cdb_valid); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b1001) begin failures++; $display("FAIL flush_resume_ready got=%b exp=1001", req_ready); end
        @(posedge clk); #1;
        checks++;
        if (cdb_valid !== 2'b11 || cdb_rob_id[4:0] !== rob_of(3)) begin
            failures++; $display("FAIL flush_resume_cdb got=%b %0d exp=11 %0d", cdb_valid, cdb_rob_id[4:0], rob_of(3));
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_random();
        int ptr = 0;
        logic [NR-1:0] held = '0;
        int wait_cnt [NR];
        logic [NR-1:0] rdy;
        int w0, w1, nw, nptr;
        logic [CW-1:0] ecv;
        logic [RI-1:0] erob [CW];
        logic [PI-1:0] ephy [CW];
        logic [DW-1:0] eval [CW];
        reset_pulse();
        for (int i = 0; i < NR; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 59) == 0);
            flush = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < NR; i++) begin
                if (!held[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    set_payload(i, RI'($urandom), PI'($urandom), $urandom);
                end
            end
            if (rst) begin
                rdy = '0; nw = 0; nptr = 0; w0 = 0; w1 = 0;
            end else begin
                arb_model(req_valid, flush, ptr, rdy, w0, w1, nw, nptr);
            end
            ecv = (nw == 2) ? 2'b11 : ((nw == 1) ? 2'b01 : 2'b00);
            erob[0] = rst ? '0 : rob_of(w0); ephy[0] = rst ? '0 : phy_of(w0); eval[0] = rst ? '0 : val_of(w0);
            erob[1] = rst ? '0 : rob_of(w1); ephy[1] = rst ? '0 : phy_of(w1); eval[1] = rst ? '0 : val_of(w1);
            #1;
            checks++;
            if (req_ready !== rdy) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, req_ready, rdy); end
            for (int i = 0; i < NR; i++) begin
                if (rst || req_ready[i]) wait_cnt[i] = 0;
                else if (req_valid[i] && !flush) begin
                    wait_cnt[i]++;
                    checks++;
                    if (wait_cnt[i] >= 2) begin failures++; $display("FAIL rand_fairness cyc=%0d req=%0d waited=%0d max=1", c, i, wait_cnt[i]); end
                end
            end
            held = req_valid & ~rdy;
            ptr = nptr;
            @(posedge clk); #1;
            checks++;
            if (cdb_valid !== ecv) begin failures++; $display("FAIL rand_cdb_valid cyc=%0d got=%b exp=%b", c, cdb_valid, ecv); end
            for (int k = 0; k < CW; k++) begin
                if (ecv[k] || rst) begin
                    checks++;
                    if (cdb_rob_id[k*RI +: RI] !== erob[k] || cdb_rd_phy[k*PI +: PI] !== ephy[k] || cdb_rd_value[k*DW +: DW] !== eval[k]) begin
                        failures++;
                        $display("FAIL rand_slot%0d cyc=%0d got=%0d/%0d/%h exp=%0d/%0d/%h", k, c,
                                 cdb_rob_id[k*RI +: RI], cdb_rd_phy[k*PI +: PI], cdb_rd_value[k*DW +: DW], erob[k], ephy[k], eval[k]);
                    end
                end
            end
        end
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; req_valid = '0;
    endtask

`ifdef CDB_ARB_STATS_EN
    task automatic test_stats();
        int s_sum = 0;
        int g_sum = 0;
        reset_pulse();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_valid = 4'b0111;
            @(posedge clk);
        end
        #1;
        for (int i = 0; i < NR; i++) begin
            s_sum += int'(stall_cnt[i*32 +: 32]);
            g_sum += int'(grant_cnt[i*32 +: 32]);
        end
        checks++;
        if (s_sum != 10) begin failures++; $display("FAIL stats_stall_sum got=%0d exp=10", s_sum); end
        checks++;
        if (g_sum != 20) begin failures++; $display("FAIL stats_grant_sum got=%0d exp=20", g_sum); end
        @(negedge clk);
        req_valid = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_contention();
        test_wrap();
        test_flush();
        test_random();
`ifdef CDB_ARB_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
